// File: rtl/traffic_light_controller_multi.sv
// N-way traffic light controller: fixed-rotation green with GREEN -> YELLOW -> ALL_RED
// handover, per-way pedestrian walk extension and a flashing-yellow failsafe mode.
module traffic_light_controller_multi #(
  parameter int N_WAYS          = 2,
  parameter int GREEN_TICKS     = 20,
  parameter int YELLOW_TICKS    = 7,
  parameter int ALLRED_TICKS    = 2,
  parameter int PED_EXTRA_TICKS = 10,
  parameter int FLASH_TICKS     = 8,
  parameter int CNT_W           = 6,
  localparam int WAY_W          = $clog2(N_WAYS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              flash,
  input  logic [N_WAYS-1:0] ped_req,
  output logic [N_WAYS-1:0] red,
  output logic [N_WAYS-1:0] yellow,
  output logic [N_WAYS-1:0] green,
  output logic [N_WAYS-1:0] walk,
  output logic [WAY_W-1:0]  active_way
);

  typedef enum logic [1:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_FLASH
  } state_e;

  localparam logic [CNT_W-1:0] ALLRED_LAST    = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST     = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] GREEN_PED_LAST = CNT_W'(GREEN_TICKS + PED_EXTRA_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST     = CNT_W'(FLASH_TICKS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY       = WAY_W'(N_WAYS - 1);

  state_e              state, state_d;
  logic [CNT_W-1:0]    count, count_d;
  logic [WAY_W-1:0]    way_d, next_way;
  logic [N_WAYS-1:0]   ped_pend, ped_pend_d;
  logic                walk_act, walk_act_d;
  logic                flash_on, flash_on_d;
  // Forces the next green to way 0 after reset or after leaving flash mode.
  logic                restart, restart_d;

  // NOTE: every register, including ped_pend, has an async reset value so the lamps
  // are safe the instant reset_n falls; all state updates use non-blocking assignment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_ALL_RED;
      count      <= '0;
      active_way <= '0;
      ped_pend   <= '0;
      walk_act   <= 1'b0;
      flash_on   <= 1'b0;
      restart    <= 1'b1;
    end else begin
      state      <= state_d;
      count      <= count_d;
      active_way <= way_d;
      ped_pend   <= ped_pend_d;
      walk_act   <= walk_act_d;
      flash_on   <= flash_on_d;
      restart    <= restart_d;
    end
  end

  assign next_way = (restart || active_way == LAST_WAY) ? '0 : active_way + WAY_W'(1);

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    state_d    = state;
    count_d    = count;
    way_d      = active_way;
    ped_pend_d = ped_pend | ped_req;
    walk_act_d = walk_act;
    flash_on_d = flash_on;
    restart_d  = restart;

    if (flash) begin
      if (state != S_FLASH) begin
        state_d    = S_FLASH;
        count_d    = '0;
        flash_on_d = 1'b1;
        walk_act_d = 1'b0;
      end else if (enable) begin
        if (count == FLASH_LAST) begin
          count_d    = '0;
          flash_on_d = ~flash_on;
        end else begin
          count_d = count + CNT_W'(1);
        end
      end
    end else if (state == S_FLASH) begin
      state_d    = S_ALL_RED;
      count_d    = '0;
      way_d      = '0;
      flash_on_d = 1'b0;
      restart_d  = 1'b1;
    end else if (enable) begin
      count_d = count + CNT_W'(1);
      unique case (state)
        S_ALL_RED: if (count == ALLRED_LAST) begin
          state_d   = S_GREEN;
          count_d   = '0;
          way_d     = next_way;
          restart_d = 1'b0;
          for (int i = 0; i < N_WAYS; i++) begin
            if (WAY_W'(i) == next_way) begin
              walk_act_d    = ped_pend[i] | ped_req[i];
              ped_pend_d[i] = 1'b0;
            end
          end
        end
        S_GREEN: if (count == (walk_act ? GREEN_PED_LAST : GREEN_LAST)) begin
          state_d    = S_YELLOW;
          count_d    = '0;
          walk_act_d = 1'b0;
        end
        S_YELLOW: if (count == YELLOW_LAST) begin
          state_d = S_ALL_RED;
          count_d = '0;
        end
        default: begin
          state_d = S_ALL_RED;
          count_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    red    = '1;
    yellow = '0;
    green  = '0;
    walk   = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      if (state == S_FLASH) begin
        red[i]    = 1'b0;
        yellow[i] = flash_on;
      end else if (active_way == WAY_W'(i)) begin
        if (state == S_GREEN) begin
          red[i]   = 1'b0;
          green[i] = 1'b1;
          walk[i]  = walk_act;
        end else if (state == S_YELLOW) begin
          red[i]    = 1'b0;
          yellow[i] = 1'b1;
        end
      end
    end
  end

endmodule
